sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: number of entries; power of two, at least 4.
REQ-002 SHALL have parameter FIFO_WIDTH, default 8: data word width in bits.
REQ-003 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-2: count at or above which almost_full asserts; range 1..FIFO_DEPTH-1.
REQ-004 SHALL have parameter AE_LEVEL, default 1: count at or below which almost_empty asserts; range 0..FIFO_DEPTH-2.
REQ-005 SHALL have parameter FWFT, default 0: 0 selects registered-read mode, 1 selects first-word-fall-through mode.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port w_en, input, 1 bit: write request.
REQ-009 SHALL have port r_en, input, 1 bit: read request (FWFT=1: pop request).
REQ-010 SHALL have port data_in, input, FIFO_WIDTH bits: write data.
REQ-011 SHALL have port clr_err, input, 1 bit: clears the sticky error flags.
REQ-012 SHALL have port data_out, output, FIFO_WIDTH bits: read data.
REQ-013 SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit: registered status flags.
REQ-014 SHALL have port count, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy, range 0..FIFO_DEPTH.
REQ-015 SHALL have ports overflow and underflow, each output, 1 bit: sticky error flags.

Function
REQ-016 SHALL accept a write iff w_en=1 and full=0; an accepted write stores data_in at wr_ptr and increments wr_ptr modulo FIFO_DEPTH.
REQ-017 SHALL accept a read iff r_en=1 and empty=0; an accepted read increments rd_ptr modulo FIFO_DEPTH.
REQ-018 SHALL apply these rules to simultaneous requests: both accepted leaves count unchanged; on full only the read is accepted; on empty only the write is accepted.
REQ-019 SHALL set count(next) = count + write accepted - read accepted, with no wrap of count.
REQ-020 SHALL register every flag from next-cycle count, so flags always agree with count in the same cycle: full = (count==FIFO_DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-021 SHALL, when FWFT=0, load data_out with mem[rd_ptr] on the clock edge of an accepted read, valid one cycle after r_en, and hold data_out otherwise.
REQ-022 SHALL, when FWFT=1, drive data_out with mem[rd_ptr] whenever empty=0, so the head word is visible with zero latency; the first write into an empty FIFO appears on data_out the cycle after it is written.
REQ-023 SHALL, when FWFT=1 and empty=1, drive data_out with the last presented value.
REQ-024 SHALL set overflow on any cycle with w_en=1 and full=1, and set underflow on any cycle with r_en=1 and empty=1.
REQ-025 SHALL clear overflow and underflow on clr_err=1; a set event in the same cycle as clr_err takes priority.
REQ-026 SHALL leave pointers, count and memory unchanged by any rejected request.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, set wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0 and data_out=0.
REQ-028 SHALL give rst priority over all other inputs; a reset asserted mid-operation discards the contents, and the memory array itself is not reset.

Structure
REQ-029 SHALL place the count-width helper function and the parameter defaults in shared package fifo_pkg.
REQ-030 SHALL instantiate a single sub-module fifo_ram: a simple dual-port array with synchronous write and asynchronous read; pointer, flag and output logic stay in the top level.

Verification
REQ-031 SHALL cover fill: with defaults, FWFT=0, after reset write 8 words 0x01..0x08 -> count 8, full=1, almost_full asserted at count 6; a 9th write sets overflow=1 and leaves count=8.
REQ-032 SHALL cover drain: read 8 words -> data_out shows 0x01..0x08 each one cycle after r_en, empty=1 and almost_empty=1 at count<=1; a 9th read sets underflow=1.
REQ-033 SHALL cover simultaneous access: with count=4, assert w_en and r_en for 10 cycles -> count stays 4, order is preserved, and pointers wrap past 7 to 0.
REQ-034 SHALL cover the boundaries: on full with w_en=r_en=1 only the read is accepted (count 8 to 7); on empty with both asserted only the write is accepted (count 0 to 1).
REQ-035 SHALL cover FWFT=1: write 0xA5 into an empty FIFO -> data_out=0xA5 the next cycle with r_en low; then r_en=1 -> empty=1.
REQ-036 SHALL cover reset: assert rst with count=5 and overflow=1 -> all outputs match REQ-027 the next cycle; clr_err=1 clears the sticky flags.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared parameter defaults and width helper for the FIFO
package fifo_pkg;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_FIFO_WIDTH = 8;
  localparam int DEF_AE_LEVEL   = 1;
  localparam int DEF_FWFT       = 0;

  // Occupancy needs one bit more than the pointer so that "full" is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port storage, synchronous write, asynchronous read
module fifo_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised synchronous FIFO with registered flags and FWFT option
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = DEF_AE_LEVEL,
  parameter int FWFT       = DEF_FWFT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_en,
  input  logic                         r_en,
  input  logic [FIFO_WIDTH-1:0]        data_in,
  input  logic                         clr_err,
  output logic [FIFO_WIDTH-1:0]        data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [cnt_w(FIFO_DEPTH)-1:0] count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = cnt_w(FIFO_DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  af_q, af_d, ae_q, ae_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic [FIFO_WIDTH-1:0] rd_data;
  logic                  wr_acc, rd_acc;

  fifo_ram #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Acceptance, pointer/count update, flags from next count, sticky errors and read data.
  always_comb begin
    wr_acc   = w_en && !full_q;
    rd_acc   = r_en && !empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    full_d   = (count_d == CW'(FIFO_DEPTH));
    empty_d  = (count_d == '0);
    af_d     = (count_d >= CW'(AF_LEVEL));
    ae_d     = (count_d <= CW'(AE_LEVEL));
    // A new error event wins over a clear in the same cycle.
    ovf_d    = (w_en && full_q) || (ovf_q && !clr_err);
    unf_d    = (r_en && empty_q) || (unf_q && !clr_err);
    dout_d   = dout_q;
    if (FWFT != 0) begin
      // Track the head so the last presented word survives the FIFO going empty.
      if (!empty_q) dout_d = rd_data;
    end else if (rd_acc) begin
      dout_d = rd_data;
    end
  end

  // State register; reset discards contents but leaves the storage array alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  assign data_out     = (FWFT != 0 && !empty_q) ? rd_data : dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] d0_dout, d1_dout;
  logic       d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
  logic       d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
  logic [3:0] d0_count, d1_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;

  always #5 clk = ~clk;

  sync_fifo_param #(.FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in), .clr_err(clr_err),
    .data_out(d0_dout), .full(d0_full), .empty(d0_empty), .almost_full(d0_af),
    .almost_empty(d0_ae), .count(d0_count), .overflow(d0_ovf), .underflow(d0_unf)
  );

  sync_fifo_param #(.FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in), .clr_err(clr_err),
    .data_out(d1_dout), .full(d1_full), .empty(d1_empty), .almost_full(d1_af),
    .almost_empty(d1_ae), .count(d1_count), .overflow(d1_ovf), .underflow(d1_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    rst = 1'b0;
    chk("rst_count", d0_count, 0);
    chk("rst_empty", d0_empty, 1);
    chk("rst_ae", d0_ae, 1);
    chk("rst_full", d0_full, 0);
    chk("rst_af", d0_af, 0);
    chk("rst_ovf", d0_ovf, 0);
    chk("rst_unf", d0_unf, 0);
    chk("rst_dout", d0_dout, 0);

    // Fill with 0x01..0x08
    w_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_in = 8'(i);
      tick();
      chk($sformatf("fill_count%0d", i), d0_count, i);
      chk($sformatf("fill_af%0d", i), d0_af, (i >= 6) ? 1 : 0);
      chk($sformatf("fill_full%0d", i), d0_full, (i == 8) ? 1 : 0);
    end
    data_in = 8'h09;
    tick();
    w_en = 1'b0;
    chk("ovf_set", d0_ovf, 1);
    chk("ovf_count", d0_count, 8);

    // Drain, each word one cycle after r_en
    r_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("drain_dout%0d", i), d0_dout, i);
      chk($sformatf("drain_count%0d", i), d0_count, 8 - i);
      chk($sformatf("drain_empty%0d", i), d0_empty, (i == 8) ? 1 : 0);
      chk($sformatf("drain_ae%0d", i), d0_ae, (8 - i <= 1) ? 1 : 0);
    end
    tick();
    r_en = 1'b0;
    chk("unf_set", d0_unf, 1);
    chk("unf_count", d0_count, 0);
    chk("unf_dout_hold", d0_dout, 8'h08);

    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_ovf", d0_ovf, 0);
    chk("clr_unf", d0_unf, 0);

    // Empty with both requests: only the write goes in
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h55;
    tick();
    r_en = 1'b0;
    chk("empty_both_count", d0_count, 1);
    chk("empty_both_dout", d0_dout, 8'h08);
    exp_q.push_back(8'h55);

    // Bring to count 4
    for (int i = 0; i < 3; i++) begin
      data_in = 8'h56 + 8'(i);
      exp_q.push_back(data_in);
      tick();
    end
    chk("pre_sim_count", d0_count, 4);

    // Ten simultaneous cycles: occupancy stays at 4, pointers wrap
    r_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      data_in = 8'h60 + 8'(k);
      exp_q.push_back(data_in);
      tick();
      exp_word = exp_q.pop_front();
      chk($sformatf("sim_dout%0d", k), d0_dout, exp_word);
      chk($sformatf("sim_count%0d", k), d0_count, 4);
    end
    r_en = 1'b0;

    // Fill to full, then both: only the read is accepted
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h70 + 8'(i);
      tick();
    end
    chk("full_count", d0_count, 8);
    chk("full_flag", d0_full, 1);
    r_en = 1'b1; data_in = 8'h99;
    tick();
    w_en = 1'b0;
    chk("full_both_count", d0_count, 7);
    chk("full_both_dout", d0_dout, 8'h66);
    chk("full_both_full", d0_full, 0);
    chk("full_both_ovf", d0_ovf, 1);

    // Down to 5 entries with overflow still set, then reset
    tick();
    chk("pre_rst_dout_a", d0_dout, 8'h67);
    tick();
    r_en = 1'b0;
    chk("pre_rst_dout_b", d0_dout, 8'h68);
    chk("pre_rst_count", d0_count, 5);
    chk("pre_rst_ovf", d0_ovf, 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", d0_count, 0);
    chk("mid_rst_empty", d0_empty, 1);
    chk("mid_rst_ae", d0_ae, 1);
    chk("mid_rst_full", d0_full, 0);
    chk("mid_rst_af", d0_af, 0);
    chk("mid_rst_ovf", d0_ovf, 0);
    chk("mid_rst_unf", d0_unf, 0);
    chk("mid_rst_dout", d0_dout, 0);
    chk("mid_rst_dout_fwft", d1_dout, 0);

    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("unf_again", d0_unf, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("unf_cleared", d0_unf, 0);

    // First-word-fall-through
    w_en = 1'b1; data_in = 8'hA5;
    tick();
    w_en = 1'b0;
    chk("fwft_dout", d1_dout, 8'hA5);
    chk("fwft_empty", d1_empty, 0);
    chk("regrd_dout_unloaded", d0_dout, 0);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("fwft_pop_empty", d1_empty, 1);
    chk("fwft_pop_count", d1_count, 0);
    chk("fwft_hold_dout", d1_dout, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
